// File: rtl/uncached_load_unit_pkg.sv
// Shared definitions for the uncached load unit: FSM encoding, access size codes,
// AXI response codes and the default read ID.
package uncached_load_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_AR   = 3'd2,
    ST_R    = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] DEFAULT_ARID = 4'b0010;

endpackage

// File: rtl/uncached_load_unit_load_extend.sv
// Lane select and sign/zero extension of a 32-bit bus word; shared by the
// cached and uncached load paths.
module load_extend
  import uncached_load_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data32_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
  assign half_sel = rdata_i[{lane_i[1], 4'b0000} +: 16];

  // NOTE: data32_o gets a value on every path (default arm included) so no latch is inferred.
  always_comb begin
    case (size_i)
      SZ_B:    data32_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_H:    data32_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: data32_o = rdata_i;  // word, and the illegal code 3
    endcase
  end

endmodule

// File: rtl/uncached_load_unit.sv
// Uncached load engine: arbitrates for the shared AXI load bus, issues one
// single-beat read sized to the access, and holds the extended result until advance.
module uncached_load_unit
  import uncached_load_unit_pkg::*;
#(
  parameter int              ID_W          = 4,
  parameter logic [ID_W-1:0] ARID          = ID_W'(DEFAULT_ARID),
  parameter int              ADDR_W        = 32,
  parameter bit              ERR_ZERO_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AXI_Load_Bus_busy,
  output logic              ul_req,
  input  logic              ul_grnt,
  output logic [ID_W-1:0]   ul_arid,
  output logic [ADDR_W-1:0] ul_araddr,
  output logic [3:0]        ul_arlen,
  output logic [2:0]        ul_arsize,
  output logic [1:0]        ul_arburst,
  output logic [1:0]        ul_arlock,
  output logic [3:0]        ul_arcache,
  output logic [2:0]        ul_arprot,
  output logic              ul_arvalid,
  input  logic              ul_arready,
  input  logic [ID_W-1:0]   ul_rid,
  input  logic [31:0]       ul_rdata,
  input  logic [1:0]        ul_rresp,
  input  logic              ul_rlast,
  input  logic              ul_rvalid,
  output logic              ul_rready,
  input  logic              cpu_uncached,
  input  logic              cpu_re,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_signed,
  input  logic              cpu_advance,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic              cpu_stall
);

  state_e      state_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q;
  logic [31:0] ext_data;
  logic        need_read, beat_ok, is_word, is_half;

  // Single beat with arlen 0, so rlast carries no information; rresp[0] only
  // distinguishes DECERR from SLVERR, which are reported alike.
  logic unused_inputs;
  assign unused_inputs = ^{ul_rlast, ul_rresp[0]};

  assign need_read = cpu_uncached & cpu_re;
  assign beat_ok   = ul_rvalid & (ul_rid == ARID);
  assign is_word   = cpu_size[1];
  assign is_half   = (cpu_size == SZ_H);

  load_extend u_load_extend (
    .rdata_i  (ul_rdata),
    .lane_i   (cpu_addr[1:0]),
    .size_i   (cpu_size),
    .signed_i (cpu_signed),
    .data32_o (ext_data)
  );

  assign rdata_d = (ERR_ZERO_DATA && ul_rresp[1]) ? 32'd0 : ext_data;

  // Address and size are taken live from the CPU; the stall keeps them stable.
  assign ul_arid    = ARID;
  assign ul_araddr  = {cpu_addr[ADDR_W-1:2], cpu_addr[1] & ~is_word, cpu_addr[0] & ~(is_word | is_half)};
  assign ul_arsize  = {1'b0, cpu_size};
  assign ul_arlen   = 4'd0;
  assign ul_arburst = 2'd0;
  assign ul_arlock  = 2'd0;
  assign ul_arcache = 4'd0;
  assign ul_arprot  = 3'd0;

  assign ul_req     = (state_q == ST_REQ) | (state_q == ST_AR) | (state_q == ST_R);
  assign ul_arvalid = (state_q == ST_AR);
  assign ul_rready  = (state_q == ST_R);
  assign cpu_stall  = ((state_q == ST_IDLE) & need_read) | ul_req;
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (need_read && !AXI_Load_Bus_busy) state_q <= ST_REQ;
        ST_REQ:  if (ul_grnt) state_q <= ST_AR;
        ST_AR:   if (ul_arready) state_q <= ST_R;
        ST_R: begin
          if (beat_ok) begin
            rdata_q <= rdata_d;
            err_q   <= ul_rresp[1];
            state_q <= ST_DONE;
          end
        end
        ST_DONE: if (cpu_advance) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uncached_load_unit.md
Name: uncached_load_unit

Overview:
- Parametrised successor to the single-word uncached load engine in the MEM stage.
- Issues one AXI3 single-beat read per uncached CPU load, with the transfer size taken from the access (byte, half or word).
- Extracts the addressed lane and sign- or zero-extends it, reports bus errors, and holds the result until the pipeline advances.
- Sits between the MEM-stage load path and the shared AXI load-bus arbiter (req/grnt).

Parameters:
- ARID, 4'b0010: AXI read ID driven on arid; only R beats carrying this rid are accepted.
- ID_W, 4: width of arid and rid.
- ADDR_W, 32: CPU and AXI address width.
- ERR_ZERO_DATA, 1: when 1, an error response forces cpu_rdata to 0; when 0, the extended bus data is passed through.

Ports:
- clk  in  1  Single clock.
- rst_n  in  1  Reset, synchronous, active-low.
- AXI_Load_Bus_busy  in  1  Shared load bus owned by another master.
- ul_req  out  1  Arbitration request.
- ul_grnt  in  1  Arbitration grant.
- ul_arid  out  ID_W  Read ID, equal to ARID.
- ul_araddr  out  ADDR_W  Read address, aligned to the access size.
- ul_arlen  out  4  Burst length, constant 0.
- ul_arsize  out  3  Transfer size, {1'b0, cpu_size}.
- ul_arburst  out  2  Constant 0.
- ul_arlock  out  2  Constant 0.
- ul_arcache  out  4  Constant 0.
- ul_arprot  out  3  Constant 0.
- ul_arvalid  out  1  Address valid.
- ul_arready  in  1  Address ready.
- ul_rid  in  ID_W  Read data ID.
- ul_rdata  in  32  Read data.
- ul_rresp  in  2  Read response.
- ul_rlast  in  1  Last beat.
- ul_rvalid  in  1  Data valid.
- ul_rready  out  1  Data ready.
- cpu_uncached  in  1  Access is uncached.
- cpu_re  in  1  Access is a load.
- cpu_addr  in  ADDR_W  Byte address of the load.
- cpu_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- cpu_signed  in  1  1 = sign-extend, 0 = zero-extend.
- cpu_advance  in  1  Pipeline consumes the MEM result this cycle.
- cpu_rdata  out  32  Extended load result.
- cpu_err  out  1  Result came from an error response (SLVERR or DECERR).
- cpu_stall  out  1  Stall request to the pipeline.

Behaviour:
- Definitions: need_read = cpu_uncached & cpu_re. Lane = cpu_addr[1:0]. Alignment masks addr[0] for half and addr[1:0] for word; misalignment exceptions are resolved upstream.
- States: IDLE, REQ, AR, R, DONE. State is encoded in the shared package.
- Outputs decoded from the registered state:
  - ul_req = 1 in REQ, AR and R.
  - ul_arvalid = 1 only in AR.
  - ul_rready = 1 only in R.
- cpu_stall = (IDLE & need_read) | REQ | AR | R. In DONE, cpu_stall = 0.
- cpu_rdata and cpu_err come from registers loaded in R and are stable through DONE.
- IDLE transitions:
  - need_read & ~AXI_Load_Bus_busy -> REQ.
  - Otherwise stay in IDLE. While AXI_Load_Bus_busy is high, no request is raised.
- REQ: ul_grnt -> AR. Otherwise hold; ul_req stays high.
- AR: ul_arvalid & ul_arready -> R. The address and size are presented combinationally from the CPU inputs, which the stall holds stable.
- R transitions:
  - A beat is taken when ul_rvalid & ul_rid == ARID. It captures the data, sets cpu_err = ul_rresp[1], and goes -> DONE.
  - Beats with a foreign rid are ignored, and the unit stays in R.
  - ul_rlast is not checked, since arlen is 0.
- DONE transitions:
  - cpu_advance -> IDLE.
  - Otherwise hold. The result stays valid and stable, and no re-issue occurs for the same instruction.
- Extension: the selected byte is rdata[8*lane +: 8]; the selected half is rdata[16*lane[1] +: 16]. The result is sign- or zero-extended to 32 bits. Word accesses pass rdata through.
- Error handling: with cpu_err = 1 and ERR_ZERO_DATA = 1, cpu_rdata = 0.
- Minimum latency: request seen in cycle 0; grant in cycle 1; arready in cycle 2; rvalid in cycle 3; DONE in cycle 4. cpu_stall is high in cycles 0-3.
- Reset: rst_n = 0 at a clock edge forces IDLE, cpu_rdata = 0 and cpu_err = 0. All valid, ready and req outputs drop the next cycle, including mid-transaction. The interconnect is reset alongside.

Decomposition:
- Shared package holds:
  - State encoding.
  - Size codes SZ_B, SZ_H, SZ_W.
  - RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - Default ARID.
- One sub-module, load_extend: a combinational block with inputs rdata, lane, size and signed, and output data32. It is shared with the cached load path.

Test Plan:
- LW at 0xBFD0_0004; grant and arready immediate; rdata 0x1234_5678, rresp 0 -> cpu_stall high for 4 cycles, DONE gives cpu_rdata 0x1234_5678, cpu_err 0, arsize 2, araddr 0xBFD0_0004.
- LB signed at 0x...0003; rdata 0x80FF_FFFF -> arsize 0, araddr keeps low bits 3, cpu_rdata 0xFFFF_FF80. Same access with LBU -> 0x0000_0080.
- LH signed at 0x...0002; rdata 0x7FFE_0000 -> cpu_rdata 0x0000_7FFE. LH at 0x...0001 -> araddr low bits 0.
- AXI_Load_Bus_busy held high for 5 cycles while need_read -> ul_req stays 0 and cpu_stall stays 1. req rises the cycle after busy falls.
- Foreign rid 4'b0001 beat in R -> ignored. A following ARID beat with rresp 2'b10 -> cpu_err 1, cpu_rdata 0.
- cpu_advance held low for 3 cycles in DONE -> no new AR issued and cpu_rdata stable. rst_n pulled low while in AR -> next cycle IDLE with ul_arvalid 0 and ul_req 0.
